uart_agent_bfm: RTL and testbench
=================================

# uart_agent_bfm

Synthesizable UART transmitter and receiver pair behind one interface, clocked by the system clock. The transmitter serializes parallel bytes onto `tx`; the receiver deserializes `rx` into bytes and flags errors. Wiring `tx` to `rx` gives the loopback used by the system-level bench.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: `pclk` cycles per serial bit; must be even and ≥4.
- `DATA_WIDTH`, default 8: data bits per frame, 5–8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `pclk`  in  1: system clock; all logic on rising edge.
- `areset`  in  1: synchronous, active-low reset.
- `tx_data`  in  DATA_WIDTH: byte to send.
- `tx_valid`  in  1: send request.
- `tx_ready`  out  1: transmitter idle, can accept.
- `tx`  out  1: serial output; idles high.
- `rx`  in  1: serial input, asynchronous.
- `rx_data`  out  DATA_WIDTH: last received byte.
- `rx_valid`  out  1: one-cycle strobe when a byte is received.
- `rx_parity_err`  out  1: qualified by `rx_valid`.
- `rx_framing_err`  out  1: qualified by `rx_valid`.

## Operation
- Frame format: start bit (0), data bits LSB first, optional parity bit, then `STOP_BITS` stop bits (1).
- Transmit FSM states: IDLE, START, DATA, PARITY, STOP.
  - `tx_ready`=1 only in IDLE.
  - A handshake occurs on a cycle with `tx_valid && tx_ready`. It latches `tx_data` and moves the FSM to START.
  - Each bit is held for exactly `CLKS_PER_BIT` cycles.
  - PARITY is skipped when `PARITY_EN`=0.
  - After the last stop bit the FSM returns to IDLE.
  - `tx` is registered.
- Receive path:
  - `rx` passes through a 2-flop synchronizer; both flops reset to 1.
  - IDLE: on synchronized `rx`=0, go to START.
  - START: wait `CLKS_PER_BIT/2` cycles, then resample. If the line is high, treat it as a glitch and return to IDLE. If low, go to DATA.
  - DATA, then PARITY if enabled: sample every `CLKS_PER_BIT` cycles, at mid-bit.
  - STOP: sample the first stop bit at mid-bit, then assert `rx_valid` on the next cycle with `rx_data`, `rx_parity_err` and `rx_framing_err`.
  - Parity error: received parity bit differs from the computed parity.
  - Framing error: sampled stop bit is 0.
  - A second stop bit is not checked.
  - After STOP the FSM returns to IDLE only once the line is high, so a framing error never retriggers on the same low level.
- `rx_data` and both error flags hold until the next `rx_valid`.
- There is no receive backpressure.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, both error flags 0, both FSMs IDLE.
- Reset mid-frame aborts both FSMs. `tx` is 1 at the first edge with `areset`=0.
- Transmit:
  - Handshake at edge N → `tx`=0 from edge N+1.
  - Frame length is (1+DATA_WIDTH+PARITY_EN+STOP_BITS)·`CLKS_PER_BIT` cycles.
  - `tx_ready` returns to 1 in the cycle after the final stop bit ends.
  - The next handshake can occur in that same cycle, giving gapless back-to-back frames.
- Receive: `rx_valid` asserts 2 (synchronizer) + (1+DATA_WIDTH+PARITY_EN)·`CLKS_PER_BIT` + `CLKS_PER_BIT/2` + 1 cycles after the falling start edge on `rx`, ±1.
- Glitches shorter than `CLKS_PER_BIT/2` produce no output.
- `tx_valid` while `tx_ready`=0 is ignored. `tx_data` may change freely after the handshake.

## Structure
- Package `uart_pkg` holds:
  - the tx state enum and the rx state enum;
  - a parity function taking data and the odd/even select;
  - the localparam for frame bit count.
- One sub-module, `uart_bit_counter`, is instantiated once per direction. It is a loadable down-counter that generates the bit tick and the half-bit tick.
- The top level holds both FSMs, the shift registers and the synchronizer.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, `DATA_WIDTH`=8, `tx` looped to `rx`.
- Reset: hold `areset` low 2 cycles, release → `tx`=1, `tx_ready`=1, `rx_valid`=0, error flags 0.
- Send 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. One `rx_valid` pulse with `rx_data`=0xA5 and no errors. Total frame 160 cycles.
- Back-to-back: `tx_valid` held with 0x00 then 0xFF → second frame starts with no idle gap. Two `rx_valid` pulses, data 0x00 then 0xFF.
- `PARITY_EN`=1, even parity, send 0x07 → parity bit 1 on the line and no error.
  - Drive `rx` directly with parity inverted → `rx_parity_err`=1 with `rx_valid`.
- Drive `rx` low for 4 cycles → no `rx_valid`.
  - Drive a frame with a 0 stop bit → `rx_framing_err`=1, then no further strobe until the line returns high.
- Assert reset at bit 4 of a frame → `tx`=1 and `tx_ready`=1 after the reset edge. The partial frame produces no `rx_valid` if the receiver was also reset.

Source files
------------

// File: rtl/uart_pkg.sv
// UART agent shared types and helpers.
// State encodings, frame sizing and parity.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  localparam int MAX_DATA_WIDTH = 8;
  localparam int FRAME_BITS_MAX = 1 + MAX_DATA_WIDTH + 1 + 2;
  localparam int IDX_W = $clog2(FRAME_BITS_MAX);

  function automatic logic parity_bit(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input logic                      odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_agent_bfm_if.sv
// UART agent bus: transmit handshake, serial
// lines and receive strobe with error flags.
interface uart_agent_bfm_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx;
  logic                  rx;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_parity_err;
  logic                  rx_framing_err;

  modport master (
    output tx_data, tx_valid, rx,
    input  tx_ready, tx, rx_data, rx_valid,
    input  rx_parity_err, rx_framing_err
  );

  modport slave (
    input  tx_data, tx_valid, rx,
    output tx_ready, tx, rx_data, rx_valid,
    output rx_parity_err, rx_framing_err
  );
endinterface

// File: rtl/uart_bit_counter.sv
// Loadable bit-period down-counter.
// tick at count 0, half_tick half a bit after a full load.
module uart_bit_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                            pclk,
  input  logic                            areset,
  input  logic                            load,
  input  logic [$clog2(CLKS_PER_BIT)-1:0] load_val,
  input  logic                            run,
  output logic                            tick,
  output logic                            half_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt;

  // count down, reloading a full bit period on wrap
  always_ff @(posedge pclk) begin
    if (!areset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run) begin
      cnt <= (cnt == '0) ? FULL : cnt - CW'(1);
    end
  end

  assign tick      = run && (cnt == '0);
  assign half_tick = run && (cnt == HALF);

endmodule

// File: rtl/uart_agent_bfm.sv
// UART transmitter/receiver pair behind one bus.
// Registered tx, synchronized rx, error flags.
module uart_agent_bfm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic             pclk,
  input logic             areset,
  uart_agent_bfm_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SHORT = CW'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic PAR_ON = (PARITY_EN != 0);
  localparam logic ODD = (PARITY_ODD != 0);

  tx_state_t tx_state, tx_next;
  logic [DATA_WIDTH-1:0] tx_shreg;
  logic [MAX_DATA_WIDTH-1:0] tx_ext;
  logic [IDX_W-1:0] tx_idx;
  logic tx_par, tx_stop_idx, tx_bit;
  logic tx_fire, tx_tick, tx_run;
  logic tx_load, tx_last_data, tx_last_stop;
  logic [CW-1:0] tx_load_val;

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign tx_fire = bus.tx_valid && bus.tx_ready;
  assign tx_last_data = (tx_idx == LAST);
  assign tx_last_stop = (STOP_BITS == 1) || tx_stop_idx;

  // widen the outgoing byte for the parity helper
  always_comb begin
    tx_ext = '0;
    tx_ext[DATA_WIDTH-1:0] = bus.tx_data;
  end

  uart_bit_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_cnt (
    .pclk      (pclk),
    .areset    (areset),
    .load      (tx_load),
    .load_val  (tx_load_val),
    .run       (tx_run),
    .tick      (tx_tick),
    .half_tick ()
  );

  // tx state register
  always_ff @(posedge pclk) begin
    if (!areset) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  // tx next-state logic
  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:   if (tx_fire) tx_next = TX_START;
      TX_START:  if (tx_tick) tx_next = TX_DATA;
      TX_DATA:
        if (tx_tick && tx_last_data)
          tx_next = PAR_ON ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_next = TX_STOP;
      TX_STOP:
        if (tx_tick && tx_last_stop)
          tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // tx outputs; the last stop bit is one cycle short
  // because the idle cycle that follows completes it
  always_comb begin
    tx_run      = (tx_state != TX_IDLE);
    tx_bit      = 1'b1;
    tx_load     = tx_fire;
    tx_load_val = FULL;
    unique case (tx_state)
      TX_IDLE:   tx_bit = 1'b1;
      TX_START:  tx_bit = 1'b0;
      TX_DATA:   tx_bit = tx_shreg[0];
      TX_PARITY: tx_bit = tx_par;
      TX_STOP:   tx_bit = 1'b1;
      default:   tx_bit = 1'b1;
    endcase
    if (tx_tick && (STOP_BITS == 1) &&
        tx_next == TX_STOP && tx_state != TX_STOP) begin
      tx_load     = 1'b1;
      tx_load_val = SHORT;
    end
    if (tx_tick && tx_state == TX_STOP && !tx_last_stop) begin
      tx_load     = 1'b1;
      tx_load_val = SHORT;
    end
  end

  // tx datapath and registered line
  always_ff @(posedge pclk) begin
    if (!areset) begin
      bus.tx      <= 1'b1;
      tx_shreg    <= '0;
      tx_par      <= 1'b0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
    end else begin
      bus.tx <= tx_bit;
      if (tx_fire) begin
        tx_shreg    <= bus.tx_data;
        tx_par      <= parity_bit(tx_ext, ODD);
        tx_idx      <= '0;
        tx_stop_idx <= 1'b0;
      end else if (tx_tick) begin
        if (tx_state == TX_DATA) begin
          tx_shreg <= tx_shreg >> 1;
          tx_idx   <= tx_idx + IDX_W'(1);
        end
        if (tx_state == TX_STOP) tx_stop_idx <= 1'b1;
      end
    end
  end

  rx_state_t rx_state, rx_next;
  logic rx_s1, rx_s2;
  logic [DATA_WIDTH-1:0] rx_shreg;
  logic [MAX_DATA_WIDTH-1:0] rx_ext;
  logic [IDX_W-1:0] rx_idx;
  logic rx_par_bit;
  logic rx_tick, rx_half, rx_run, rx_load;

  // two-flop synchronizer, idles high
  always_ff @(posedge pclk) begin
    if (!areset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
    end
  end

  // widen the received byte for the parity helper
  always_comb begin
    rx_ext = '0;
    rx_ext[DATA_WIDTH-1:0] = rx_shreg;
  end

  uart_bit_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_cnt (
    .pclk      (pclk),
    .areset    (areset),
    .load      (rx_load),
    .load_val  (FULL),
    .run       (rx_run),
    .tick      (rx_tick),
    .half_tick (rx_half)
  );

  // rx state register
  always_ff @(posedge pclk) begin
    if (!areset) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  // rx next-state logic
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_s2) rx_next = RX_START;
      RX_START:
        if (rx_half)
          rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_tick && rx_idx == LAST)
          rx_next = PAR_ON ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_next = RX_STOP;
      RX_STOP:
        if (rx_tick)
          rx_next = rx_s2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // rx counter control; restart at mid start bit
  always_comb begin
    rx_run  = 1'b0;
    rx_load = 1'b0;
    unique case (rx_state)
      RX_IDLE:   rx_load = !rx_s2;
      RX_START: begin
        rx_run  = 1'b1;
        rx_load = rx_half;
      end
      RX_DATA:   rx_run = 1'b1;
      RX_PARITY: rx_run = 1'b1;
      RX_STOP:   rx_run = 1'b1;
      default:   rx_run = 1'b0;
    endcase
  end

  // rx datapath, strobe and sticky result flags
  always_ff @(posedge pclk) begin
    if (!areset) begin
      rx_shreg           <= '0;
      rx_idx             <= '0;
      rx_par_bit         <= 1'b0;
      bus.rx_valid       <= 1'b0;
      bus.rx_data        <= '0;
      bus.rx_parity_err  <= 1'b0;
      bus.rx_framing_err <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      if (rx_state == RX_START) rx_idx <= '0;
      if (rx_tick) begin
        if (rx_state == RX_DATA) begin
          rx_shreg <= {rx_s2, rx_shreg[DATA_WIDTH-1:1]};
          rx_idx   <= rx_idx + IDX_W'(1);
        end
        if (rx_state == RX_PARITY) rx_par_bit <= rx_s2;
        if (rx_state == RX_STOP) begin
          bus.rx_valid       <= 1'b1;
          bus.rx_data        <= rx_shreg;
          bus.rx_parity_err  <= PAR_ON &&
            (rx_par_bit != parity_bit(rx_ext, ODD));
          bus.rx_framing_err <= !rx_s2;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_agent_bfm.sv
// Directed bench for uart_agent_bfm: loopback,
// parity, glitch, framing and mid-frame reset.
module tb_uart_agent_bfm;
  logic pclk = 1'b0;
  logic areset;
  logic loop, loop_p, rx_drv, rx_drv_p;
  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int vcnt_p = 0;
  int v0;
  logic [9:0] last = '0, prev = '0;
  logic [9:0] last_p = '0;
  logic [9:0] exp_seq;

  always #5 pclk = ~pclk;

  uart_agent_bfm_if #(.DATA_WIDTH(8)) bus ();
  uart_agent_bfm_if #(.DATA_WIDTH(8)) bus_p ();

  assign bus.rx   = loop   ? bus.tx   : rx_drv;
  assign bus_p.rx = loop_p ? bus_p.tx : rx_drv_p;

  uart_agent_bfm #(
    .CLKS_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .pclk(pclk), .areset(areset), .bus(bus.slave)
  );

  uart_agent_bfm #(
    .CLKS_PER_BIT(16), .DATA_WIDTH(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_p (
    .pclk(pclk), .areset(areset), .bus(bus_p.slave)
  );

  always @(negedge pclk) begin
    if (bus.rx_valid === 1'b1) begin
      vcnt++;
      prev = last;
      last = {bus.rx_framing_err, bus.rx_parity_err,
              bus.rx_data};
    end
    if (bus_p.rx_valid === 1'b1) begin
      vcnt_p++;
      last_p = {bus_p.rx_framing_err, bus_p.rx_parity_err,
                bus_p.rx_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic drive_rx(input logic p,
                          input logic [15:0] bits,
                          input int n);
    for (int i = 0; i < n; i++) begin
      if (p) rx_drv_p = bits[i];
      else   rx_drv   = bits[i];
      tick(16);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b0;
    loop = 1'b1; loop_p = 1'b1;
    rx_drv = 1'b1; rx_drv_p = 1'b1;
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    bus_p.tx_valid = 1'b0; bus_p.tx_data = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    areset = 1'b1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_perr", bus.rx_parity_err, 0);
    chk("rst_ferr", bus.rx_framing_err, 0);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_tx_p", bus_p.tx, 1);

    // 0xA5 loopback, bit-by-bit line check
    exp_seq = 10'h34A;
    v0 = vcnt;
    bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    chk("a5_ready_low", bus.tx_ready, 0);
    chk("a5_tx_lag", bus.tx, 1);
    tick(1);
    chk("a5_start_edge", bus.tx, 0);
    tick(7);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("a5_bit%0d", b), bus.tx, exp_seq[b]);
      if (b < 9) tick(16);
    end
    tick(6);
    chk("a5_ready_158", bus.tx_ready, 0);
    tick(1);
    chk("a5_ready_159", bus.tx_ready, 1);
    tick(20);
    chk("a5_rx_count", vcnt - v0, 1);
    chk("a5_rx_word", last, 10'h0A5);

    // back-to-back 0x00 then 0xFF, valid held
    v0 = vcnt;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_data = 8'hFF;
    tick(159);
    chk("b2b_ready_159", bus.tx_ready, 1);
    chk("b2b_stop_159", bus.tx, 1);
    tick(1);
    chk("b2b_ready_160", bus.tx_ready, 0);
    chk("b2b_stop_160", bus.tx, 1);
    bus.tx_valid = 1'b0;
    tick(1);
    chk("b2b_start_161", bus.tx, 0);
    tick(180);
    chk("b2b_rx_count", vcnt - v0, 2);
    chk("b2b_rx_first", prev, 10'h000);
    chk("b2b_rx_second", last, 10'h0FF);

    // even parity, 0x07 loopback
    v0 = vcnt_p;
    bus_p.tx_data = 8'h07; bus_p.tx_valid = 1'b1;
    tick(1);
    bus_p.tx_valid = 1'b0;
    tick(136);
    chk("par_bit7", bus_p.tx, 0);
    tick(16);
    chk("par_bit_line", bus_p.tx, 1);
    tick(16);
    chk("par_stop", bus_p.tx, 1);
    tick(30);
    chk("par_rx_count", vcnt_p - v0, 1);
    chk("par_rx_word", last_p, 10'h007);

    // driven frame with parity bit inverted
    loop_p = 1'b0;
    v0 = vcnt_p;
    drive_rx(1'b1, 16'h040E, 11);
    tick(20);
    chk("perr_count", vcnt_p - v0, 1);
    chk("perr_word", last_p, 10'h107);
    loop_p = 1'b1;

    // 4-cycle glitch
    loop = 1'b0;
    v0 = vcnt;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(60);
    chk("glitch_count", vcnt - v0, 0);

    // 0x3C with a 0 stop bit, line left low
    v0 = vcnt;
    drive_rx(1'b0, 16'h0078, 10);
    tick(48);
    chk("ferr_count", vcnt - v0, 1);
    chk("ferr_word", last, 10'h23C);
    rx_drv = 1'b1;
    tick(40);
    chk("ferr_no_retrig", vcnt - v0, 1);

    // reset during data bit 4
    loop = 1'b1;
    v0 = vcnt;
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    tick(72);
    areset = 1'b0;
    tick(1);
    chk("mrst_tx", bus.tx, 1);
    chk("mrst_ready", bus.tx_ready, 1);
    chk("mrst_valid", bus.rx_valid, 0);
    chk("mrst_data", bus.rx_data, 0);
    chk("mrst_ferr", bus.rx_framing_err, 0);
    areset = 1'b1;
    tick(200);
    chk("mrst_no_strobe", vcnt - v0, 0);
    chk("mrst_idle_ready", bus.tx_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
